// File: rtl/pipeline_defs.sv
// Shared ISA field positions, opcode/aluop constants and the multdiv sequencer state encoding.
package pipeline_defs;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // add r0,r0,r0 is the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DRAIN = 2'd3
  } md_state_e;

  function automatic logic [4:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Combinational decode of one instruction into register sources, load flag and mul/div flag.
// Zero latency; purely combinational, no flow control.
module hazard_src_decode
  import pipeline_defs::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic        rs_vld_o,
  output logic        rt_vld_o,
  output logic        rd_vld_o,
  output logic        is_load_o,
  output logic        is_md_o
);

  logic [4:0] opcode;
  logic [4:0] aluop;
  logic [6:0] unused_bits;

  assign opcode      = opcode_of(instr_i);
  assign aluop       = instr_i[ALUOP_HI:ALUOP_LO];
  assign rs_o        = instr_i[RS_HI:RS_LO];
  assign rt_o        = instr_i[RT_HI:RT_LO];
  assign rd_o        = instr_i[RD_HI:RD_LO];
  assign unused_bits = {instr_i[11:7], instr_i[1:0]};

  always_comb begin
    rs_vld_o = 1'b0;
    rt_vld_o = 1'b0;
    rd_vld_o = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rs_vld_o = 1'b1;
        rt_vld_o = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        rs_vld_o = 1'b1;
      end
      // stores and compare-branches read rd as a data/compare operand
      OP_SW, OP_BNE, OP_BLT: begin
        rs_vld_o = 1'b1;
        rd_vld_o = 1'b1;
      end
      OP_JR: begin
        rd_vld_o = 1'b1;
      end
      default: begin
        rs_vld_o = 1'b0;
      end
    endcase
  end

  assign is_load_o = (opcode == OP_LW);
  assign is_md_o   = (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, branch flush and mul/div sequencing for the 5-stage pipe; stall/flush outputs are same-cycle.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import pipeline_defs::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_instruction,
  input  logic [31:0] de_instruction,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_en,
  output logic        em_en,
  output logic        fd_flush,
  output logic        de_bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] md_stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_LATENCY - 1);

  logic [4:0] fd_rs, fd_rt, fd_rd;
  logic       fd_rs_vld, fd_rt_vld, fd_rd_vld;
  logic       unused_fd_load, unused_fd_md;
  logic [4:0] unused_de_rs, unused_de_rt;
  logic       unused_de_rs_vld, unused_de_rt_vld, unused_de_rd_vld;
  logic [4:0] de_rd;
  logic       de_is_load, de_is_md;
  logic       unused_md_exception;

  hazard_src_decode u_fd_dec (
    .instr_i   (fd_instruction),
    .rs_o      (fd_rs),
    .rt_o      (fd_rt),
    .rd_o      (fd_rd),
    .rs_vld_o  (fd_rs_vld),
    .rt_vld_o  (fd_rt_vld),
    .rd_vld_o  (fd_rd_vld),
    .is_load_o (unused_fd_load),
    .is_md_o   (unused_fd_md)
  );

  hazard_src_decode u_de_dec (
    .instr_i   (de_instruction),
    .rs_o      (unused_de_rs),
    .rt_o      (unused_de_rt),
    .rd_o      (de_rd),
    .rs_vld_o  (unused_de_rs_vld),
    .rt_vld_o  (unused_de_rt_vld),
    .rd_vld_o  (unused_de_rd_vld),
    .is_load_o (de_is_load),
    .is_md_o   (de_is_md)
  );

  // md_exception rides along with md_ready for downstream use only
  assign unused_md_exception = md_exception;

  logic lu_hazard;

  assign lu_hazard = de_is_load && (de_rd != 5'd0) &&
                     ((fd_rs_vld && (fd_rs == de_rd)) ||
                      (fd_rt_vld && (fd_rt == de_rd)) ||
                      (fd_rd_vld && (fd_rd == de_rd)));

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             start_q;
  logic             busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (de_is_md && !branch_taken) begin
            state_q <= MD_START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        MD_START: begin
          state_q <= MD_WAIT;
          start_q <= 1'b0;
          cnt_q   <= '0;
        end
        MD_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (md_ready) begin
            state_q <= MD_DRAIN;
            busy_q  <= 1'b0;
          end else if (cnt_q == MD_LAST) begin
            state_q   <= MD_DRAIN;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        MD_DRAIN: begin
          state_q <= MD_IDLE;
        end
        default: begin
          state_q <= MD_IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // busy_q is high exactly in START and WAIT, which is when execute is frozen
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    if (!reset) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (busy_q) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
    end else if (branch_taken) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (lu_hazard) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_bubble = 1'b1;
    end
  end

  assign md_start   = start_q;
  assign md_busy    = busy_q;
  assign md_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, md_cnt_q, fl_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      if (!busy_q && !branch_taken && lu_hazard) lu_cnt_q <= lu_cnt_q + 32'd1;
      if (busy_q)                                md_cnt_q <= md_cnt_q + 32'd1;
      if (!busy_q && branch_taken)               fl_cnt_q <= fl_cnt_q + 32'd1;
    end
  end

  assign lu_stall_cnt = lu_cnt_q;
  assign md_stall_cnt = md_cnt_q;
  assign flush_cnt    = fl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed checks of load-use stall, branch flush priority and mul/div sequencing.
module tb_hazard_stall_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] fd_instruction;
  logic [31:0] de_instruction;
  logic        branch_taken;
  logic        md_ready;
  logic        md_exception;
  logic        pc_en, fd_en, de_en, em_en;
  logic        fd_flush, de_bubble, md_start, md_busy, md_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, md_stall_cnt, flush_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // {pc_en, fd_en, de_en, em_en, fd_flush, de_bubble, md_start, md_busy}
  localparam logic [7:0] O_RST   = 8'b1111_1100;
  localparam logic [7:0] O_IDLE  = 8'b1111_0000;
  localparam logic [7:0] O_LU    = 8'b0011_0100;
  localparam logic [7:0] O_BR    = 8'b1111_1100;
  localparam logic [7:0] O_START = 8'b0000_0011;
  localparam logic [7:0] O_WAIT  = 8'b0000_0001;

  localparam logic [31:0] NOP = 32'h0;

  hazard_stall_ctrl #(.MD_LATENCY(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .fd_instruction (fd_instruction),
    .de_instruction (de_instruction),
    .branch_taken   (branch_taken),
    .md_ready       (md_ready),
    .md_exception   (md_exception),
    .pc_en          (pc_en),
    .fd_en          (fd_en),
    .de_en          (de_en),
    .em_en          (em_en),
    .fd_flush       (fd_flush),
    .de_bubble      (de_bubble),
    .md_start       (md_start),
    .md_busy        (md_busy),
    .md_timeout     (md_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_stall_cnt   (lu_stall_cnt),
    .md_stall_cnt   (md_stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs);
    return itype(5'b01000, rd, rs, 17'd0);
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return rtype(rd, rs, rt, 5'b00000);
  endfunction

  function automatic logic [31:0] mul(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return rtype(rd, rs, rt, 5'b00110);
  endfunction

  function automatic logic [31:0] div(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return rtype(rd, rs, rt, 5'b00111);
  endfunction

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, {24'd0, pc_en, fd_en, de_en, em_en, fd_flush, de_bubble, md_start, md_busy}, {24'd0, exp});
  endtask

  initial begin
    reset          = 1'b0;
    fd_instruction = NOP;
    de_instruction = NOP;
    branch_taken   = 1'b0;
    md_ready       = 1'b0;
    md_exception   = 1'b0;

    chk_o("rst_outs", O_RST);
    chk("rst_tmo", {31'd0, md_timeout}, 32'd0);
    cyc(); chk_o("rst_outs_edge", O_RST);
    reset = 1'b1; chk_o("post_rst", O_IDLE);
    cyc(); chk_o("idle", O_IDLE);

    // load-use, then pipeline delivers the bubble into D/X
    cyc(); de_instruction = lw(5, 2); fd_instruction = add(7, 5, 1); chk_o("lu_stall", O_LU);
    cyc(); de_instruction = NOP; chk_o("lu_after", O_IDLE);
    cyc(); de_instruction = lw(0, 2); fd_instruction = add(7, 0, 1); chk_o("lu_r0", O_IDLE);
    cyc(); de_instruction = lw(9, 3); fd_instruction = itype(5'b00111, 9, 3, 17'd4); chk_o("lu_sw_rd", O_LU);
    cyc(); fd_instruction = itype(5'b00101, 4, 3, 17'h09000); chk_o("lu_addi_imm", O_IDLE);
    cyc(); fd_instruction = itype(5'b01000, 6, 9, 17'd0); chk_o("lu_lw_rs", O_LU);
    cyc(); de_instruction = lw(12, 3); fd_instruction = add(7, 1, 12); chk_o("lu_rt", O_LU);

    // branch overrides load-use
    cyc(); de_instruction = lw(5, 2); fd_instruction = add(7, 5, 1); branch_taken = 1'b1;
    chk_o("br_over_lu", O_BR);
    cyc(); branch_taken = 1'b0; de_instruction = NOP; fd_instruction = NOP; chk_o("br_no_stall", O_IDLE);

    cyc(); md_ready = 1'b1; chk_o("rdy_idle", O_IDLE);
    cyc(); md_ready = 1'b0; chk_o("rdy_idle_after", O_IDLE);

    // mul with ready 10 cycles after start
    cyc(); de_instruction = mul(3, 1, 2); chk_o("mul_idle", O_IDLE);
    cyc(); chk_o("mul_start", O_START);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 10) begin md_ready = 1'b1; md_exception = 1'b1; end
      chk_o("mul_wait", O_WAIT);
    end
    cyc(); md_ready = 1'b0; md_exception = 1'b0; de_instruction = NOP; chk_o("mul_drain", O_IDLE);
    chk("mul_tmo", {31'd0, md_timeout}, 32'd0);
    cyc(); chk_o("mul_idle2", O_IDLE);

    // branch in the same cycle as a mul in D/X suppresses the start
    cyc(); de_instruction = mul(3, 1, 2); branch_taken = 1'b1; chk_o("br_md_idle", O_BR);
    cyc(); branch_taken = 1'b0; de_instruction = NOP; chk_o("br_md_nostart", O_IDLE);

    // back-to-back mul: DRAIN, IDLE, START
    cyc(); de_instruction = mul(3, 1, 2); chk_o("b2b_idle", O_IDLE);
    cyc(); chk_o("b2b_start1", O_START);
    cyc(); md_ready = 1'b1; chk_o("b2b_wait1", O_WAIT);
    cyc(); md_ready = 1'b0; de_instruction = mul(4, 3, 2); chk_o("b2b_drain", O_IDLE);
    cyc(); chk_o("b2b_gap", O_IDLE);
    cyc(); md_ready = 1'b1; chk_o("b2b_start2", O_START);
    cyc(); md_ready = 1'b0; chk_o("b2b_wait_a", O_WAIT);
    cyc(); md_ready = 1'b1; chk_o("b2b_wait_b", O_WAIT);
    cyc(); md_ready = 1'b0; de_instruction = NOP; chk_o("b2b_drain2", O_IDLE);

    // div that never completes: 1 START + 32 WAIT, then forced release
    cyc(); de_instruction = div(4, 1, 2); chk_o("div_idle", O_IDLE);
    cyc(); chk_o("div_start", O_START);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      chk_o("div_wait", O_WAIT);
      chk("div_tmo_low", {31'd0, md_timeout}, 32'd0);
    end
    cyc(); de_instruction = NOP; chk_o("div_drain", O_IDLE);
    chk("div_tmo_set", {31'd0, md_timeout}, 32'd1);
    cyc(); md_ready = 1'b1; chk_o("div_post", O_IDLE);
    cyc(); md_ready = 1'b0; chk("div_tmo_sticky", {31'd0, md_timeout}, 32'd1);

    // reset during WAIT, late ready afterwards
    cyc(); de_instruction = mul(3, 1, 2); chk_o("rw_idle", O_IDLE);
    cyc(); chk_o("rw_start", O_START);
    cyc(); chk_o("rw_wait1", O_WAIT);
    cyc(); chk_o("rw_wait2", O_WAIT);
    cyc(); reset = 1'b0; de_instruction = NOP; chk_o("rw_rst", O_RST);
    chk("rw_tmo_clr", {31'd0, md_timeout}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(); chk_o("rw_rst_hold", O_RST);
    end
    cyc(); reset = 1'b1; chk_o("rw_rel", O_IDLE);
    cyc(); md_ready = 1'b1; chk_o("late_rdy", O_IDLE);
    cyc(); md_ready = 1'b0; chk_o("late_rdy_after", O_IDLE);
    chk("late_tmo", {31'd0, md_timeout}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
